if_pc_redirect: RTL and testbench

IF_PC_REDIRECT -- requirements
Module: if_pc_redirect

---
 rtl/if_pc_redirect.sv | 143 ++++++++++++++
 tb/tb_if_pc_redirect.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_redirect.sv
// Instruction-fetch PC sequencer: one outstanding imem request, branch redirect
// with drain of an in-flight fetch, and a one-entry hold buffer for load-use stalls.
module if_pc_redirect (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mem_branch,
  input  logic [31:0] mem_bpc,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        flush_id,
  output logic        flush_exe,
  output logic [15:0] branch_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HELD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] target_q, target_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_inst_d  = if_inst_q;
    if_pc4_d   = if_pc4_q;
    if_valid_d = if_valid_q;
    hold_d     = hold_q;
    target_d   = target_q;

    unique case (state_q)
      ST_IDLE: begin
        // any ack seen here belongs to nothing we issued
        if (mem_branch) begin
          pc_d       = mem_bpc;
          if_valid_d = 1'b0;
        end
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_branch) begin
          if_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = mem_bpc;
          end else begin
            target_d = mem_bpc;
            state_d  = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            hold_d  = imem_inst;
            state_d = ST_HELD;
          end else begin
            if_inst_d  = imem_inst;
            if_pc4_d   = pc_plus4;
            if_valid_d = 1'b1;
          end
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if_valid_d = 1'b0;
        if (imem_ack) begin
          pc_d    = mem_branch ? mem_bpc : target_q;
          state_d = ST_REQ;
        end else if (mem_branch) begin
          target_d = mem_bpc;
        end
      end
      ST_HELD: begin
        if (mem_branch) begin
          pc_d       = mem_bpc;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!stall) begin
          // pc already advanced past the held word when it was captured
          if_inst_d  = hold_q;
          if_pc4_d   = pc_q;
          if_valid_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    if (mem_branch && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q      <= ST_IDLE;
      pc_q         <= 32'd0;
      if_inst_q    <= 32'd0;
      if_pc4_q     <= 32'd0;
      if_valid_q   <= 1'b0;
      hold_q       <= 32'd0;
      target_q     <= 32'd0;
      branch_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_inst_q    <= if_inst_d;
      if_pc4_q     <= if_pc4_d;
      if_valid_q   <= if_valid_d;
      hold_q       <= hold_d;
      target_q     <= target_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign imem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign if_inst    = if_inst_q;
  assign if_pc4     = if_pc4_q;
  assign if_valid   = if_valid_q;
  assign flush_id   = mem_branch;
  assign flush_exe  = mem_branch;
  assign branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_if_pc_redirect.sv
// Directed bench for if_pc_redirect: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_if_pc_redirect;

  logic        clk = 1'b0;
  logic        clrn, mem_branch, stall, imem_ack;
  logic [31:0] mem_bpc, imem_inst;
  logic [31:0] pc, if_inst, if_pc4;
  logic        imem_req, if_valid, flush_id, flush_exe;
  logic [15:0] branch_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_pc_redirect dut (
    .clk       (clk),
    .clrn      (clrn),
    .mem_branch(mem_branch),
    .mem_bpc   (mem_bpc),
    .stall     (stall),
    .imem_ack  (imem_ack),
    .imem_inst (imem_inst),
    .pc        (pc),
    .imem_req  (imem_req),
    .if_inst   (if_inst),
    .if_pc4    (if_pc4),
    .if_valid  (if_valid),
    .flush_id  (flush_id),
    .flush_exe (flush_exe),
    .branch_cnt(branch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge; results are sampled 2 time units after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clrn = 1'b1; mem_branch = 1'b0; mem_bpc = 32'd0; stall = 1'b0;
    imem_ack = 1'b0; imem_inst = 32'd0;

    // reset
    tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_cnt", {16'd0, branch_cnt}, 32'd0);
    mem_branch = 1'b1; mem_bpc = 32'h0000_0F00;
    #1;
    chk("rst_flush_id", {31'd0, flush_id}, 32'd1);
    chk("rst_flush_exe", {31'd0, flush_exe}, 32'd1);
    tick();
    chk("rst_cnt_hold", {16'd0, branch_cnt}, 32'd0);
    chk("rst_pc_hold", pc, 32'd0);

    // first non-reset cycle: IDLE, ack ignored
    clrn = 1'b0; mem_branch = 1'b0; imem_ack = 1'b1; imem_inst = 32'hDEAD_0000;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("idle_pc", pc, 32'd0);
    chk("idle_valid", {31'd0, if_valid}, 32'd0);
    chk("req_req", {31'd0, imem_req}, 32'd1);

    // streaming fetch
    imem_inst = 32'h2008_0001;
    tick();
    chk("f0_inst", if_inst, 32'h2008_0001);
    chk("f0_pc4", if_pc4, 32'd4);
    chk("f0_valid", {31'd0, if_valid}, 32'd1);
    chk("f0_pc", pc, 32'd4);
    imem_inst = 32'h2009_0002;
    tick();
    chk("f1_inst", if_inst, 32'h2009_0002);
    chk("f1_pc4", if_pc4, 32'd8);
    chk("f1_pc", pc, 32'd8);

    // stall at ack of pc=8 -> HELD
    imem_inst = 32'hAABB_CCDD; stall = 1'b1;
    tick();
    chk("held_req", {31'd0, imem_req}, 32'd0);
    chk("held_pc", pc, 32'h0000_000C);
    chk("held_inst", if_inst, 32'h2009_0002);
    chk("held_pc4", if_pc4, 32'd8);
    imem_ack = 1'b0;
    tick();
    chk("held2_inst", if_inst, 32'h2009_0002);
    chk("held2_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("rel_inst", if_inst, 32'hAABB_CCDD);
    chk("rel_pc4", if_pc4, 32'h0000_000C);
    chk("rel_valid", {31'd0, if_valid}, 32'd1);
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    // branch with same-cycle ack
    mem_branch = 1'b1; mem_bpc = 32'h100; imem_ack = 1'b1; imem_inst = 32'hDEAD_BEEF;
    #1;
    chk("br_flush_id", {31'd0, flush_id}, 32'd1);
    chk("br_flush_exe", {31'd0, flush_exe}, 32'd1);
    tick();
    chk("br_pc", pc, 32'h100);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    chk("br_inst", if_inst, 32'hAABB_CCDD);
    chk("br_cnt", {16'd0, branch_cnt}, 32'd1);

    // branch while ack withheld -> DRAIN
    mem_bpc = 32'h200; imem_ack = 1'b0;
    tick();
    mem_branch = 1'b0;
    chk("dr_pc0", pc, 32'h100);
    chk("dr_cnt", {16'd0, branch_cnt}, 32'd2);
    tick();
    tick();
    chk("dr_pc2", pc, 32'h100);
    chk("dr_req", {31'd0, imem_req}, 32'd1);
    chk("dr_valid", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1; imem_inst = 32'h1111_1111;
    tick();
    chk("dr_pc_ack", pc, 32'h200);
    chk("dr_valid_ack", {31'd0, if_valid}, 32'd0);

    // two branches during DRAIN: latest wins
    imem_ack = 1'b0; mem_branch = 1'b1; mem_bpc = 32'h300;
    tick();
    mem_bpc = 32'h400;
    tick();
    chk("dr2_pc", pc, 32'h200);
    chk("dr2_cnt", {16'd0, branch_cnt}, 32'd4);
    mem_branch = 1'b0; imem_ack = 1'b1; imem_inst = 32'h2222_2222;
    tick();
    chk("dr2_pc_ack", pc, 32'h400);
    chk("dr2_valid", {31'd0, if_valid}, 32'd0);

    // pc wrap
    mem_branch = 1'b1; mem_bpc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    mem_branch = 1'b0; imem_inst = 32'h1234_5678;
    tick();
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_pc4", if_pc4, 32'd0);
    chk("wrap_inst", if_inst, 32'h1234_5678);

    // branch arriving together with ack in DRAIN overrides stored target
    mem_branch = 1'b1; mem_bpc = 32'h500; imem_ack = 1'b0;
    tick();
    mem_bpc = 32'h600; imem_ack = 1'b1;
    tick();
    chk("drbr_pc", pc, 32'h600);
    chk("drbr_cnt", {16'd0, branch_cnt}, 32'd7);

    // no-ack behaviour in REQ
    mem_branch = 1'b0; imem_inst = 32'hCAFE_0001;
    tick();
    chk("na_valid0", {31'd0, if_valid}, 32'd1);
    imem_ack = 1'b0; stall = 1'b1;
    tick();
    chk("na_stall_valid", {31'd0, if_valid}, 32'd1);
    chk("na_stall_pc", pc, 32'h604);
    stall = 1'b0;
    tick();
    chk("na_bubble", {31'd0, if_valid}, 32'd0);
    chk("na_pc", pc, 32'h604);

    // saturation of the branch counter
    mem_branch = 1'b1; mem_bpc = 32'h700; imem_ack = 1'b1;
    repeat (65536) @(posedge clk);
    #2;
    chk("sat_cnt", {16'd0, branch_cnt}, 32'h0000_FFFF);
    tick();
    chk("sat_cnt2", {16'd0, branch_cnt}, 32'h0000_FFFF);

    // reset from HELD
    mem_branch = 1'b0; imem_inst = 32'h7777_7777; stall = 1'b1;
    tick();
    chk("h_req", {31'd0, imem_req}, 32'd0);
    chk("h_pc", pc, 32'h704);
    clrn = 1'b1;
    tick();
    chk("hr_pc", pc, 32'd0);
    chk("hr_inst", if_inst, 32'd0);
    chk("hr_pc4", if_pc4, 32'd0);
    chk("hr_valid", {31'd0, if_valid}, 32'd0);
    chk("hr_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("hr_req", {31'd0, imem_req}, 32'd0);
    clrn = 1'b0; stall = 1'b0;
    #1;
    chk("hr_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("hr_restart_req", {31'd0, imem_req}, 32'd1);
    chk("hr_restart_pc", pc, 32'd0);
    chk("hr_restart_valid", {31'd0, if_valid}, 32'd0);
    imem_inst = 32'h0000_0ABC;
    tick();
    chk("hr_first_inst", if_inst, 32'h0000_0ABC);
    chk("hr_first_pc4", if_pc4, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
